// File: rtl/collector_pkg.sv
// Shared types and sizing helpers for the systolic result collector.
// Default geometry matches a 4-column array with a 4-cycle fill latency.
package collector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STREAM,
    DONE
  } state_e;

  localparam int DEF_LATENCY = 4;
  localparam int DEF_COLS    = 4;
  localparam int WAIT_LEN    = DEF_LATENCY + DEF_COLS - 1;
  localparam int WAIT_CNT_W  = $clog2(WAIT_LEN + 1);

  // Cycles between the start edge and the first fully aligned row.
  function automatic int wait_len(input int latency, input int cols);
    return latency + cols - 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage register chain used to remove the diagonal skew of one column.
// DEPTH=0 degenerates to a plain wire.
module skew_delay_line #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] d_in,
  output logic [DATA_SIZE-1:0] d_out
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_pins;
      assign unused_pins = clk ^ rst_n;
      assign d_out       = d_in;
    end else begin : g_regs
      logic [DEPTH-1:0][DATA_SIZE-1:0] stage_q;
      logic [DEPTH-1:0][DATA_SIZE-1:0] stage_d;

      always_comb begin
        stage_d[0] = d_in;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      // NOTE: every stage is reset, so an aborted job leaves no stale lanes behind.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign d_out = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_result_collector.sv
// Collects the skewed bottom edge of the PE array and emits one aligned,
// packed row per cycle with a valid strobe, followed by a one-cycle done pulse.
module systolic_result_collector
  import collector_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int COLS      = DEF_COLS,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int ROW_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ROW_W-1:0]          num_rows,
  input  logic [COLS*DATA_SIZE-1:0] col_in,
  output logic [COLS*DATA_SIZE-1:0] row_data,
  output logic                      row_valid,
  output logic [ROW_W-1:0]          row_index,
  output logic                      busy,
  output logic                      done
);

  localparam int WAIT_CYC = wait_len(LATENCY, COLS);
  localparam int WCNT_W   = $clog2(WAIT_CYC + 1);

  logic [COLS*DATA_SIZE-1:0] aligned;

  for (genvar j = 0; j < COLS; j++) begin : g_col
    skew_delay_line #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (COLS - 1 - j)
    ) u_delay (
      .clk   (clk),
      .rst_n (reset),
      .d_in  (col_in[j*DATA_SIZE +: DATA_SIZE]),
      .d_out (aligned[j*DATA_SIZE +: DATA_SIZE])
    );
  end

  state_e                    state_q,     state_d;
  logic [WCNT_W-1:0]         wait_cnt_q,  wait_cnt_d;
  logic [ROW_W-1:0]          rows_q,      rows_d;
  logic [ROW_W-1:0]          row_cnt_q,   row_cnt_d;
  logic [COLS*DATA_SIZE-1:0] row_data_q,  row_data_d;
  logic                      row_valid_q, row_valid_d;
  logic [ROW_W-1:0]          row_index_q, row_index_d;
  logic                      busy_q,      busy_d;
  logic                      done_q,      done_d;

  always_comb begin
    // NOTE: every variable gets a default up front so no path infers a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    rows_d      = rows_q;
    row_cnt_d   = row_cnt_q;
    row_data_d  = row_data_q;
    row_valid_d = 1'b0;
    row_index_d = row_index_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse belongs to the finished job.
        if (start && !done_q) begin
          row_index_d = '0;
          if (num_rows != '0) begin
            rows_d     = num_rows;
            wait_cnt_d = '0;
            row_cnt_d  = '0;
            state_d    = WAIT;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT: begin
        busy_d = 1'b1;
        if (wait_cnt_q == WCNT_W'(WAIT_CYC - 1)) begin
          state_d = STREAM;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      STREAM: begin
        busy_d      = 1'b1;
        row_valid_d = 1'b1;
        row_data_d  = aligned;
        row_index_d = row_cnt_q;
        row_cnt_d   = row_cnt_q + ROW_W'(1);
        // Compare before incrementing so a full-scale row count never wraps.
        if (row_cnt_q == rows_q - ROW_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      rows_q      <= '0;
      row_cnt_q   <= '0;
      row_data_q  <= '0;
      row_valid_q <= 1'b0;
      row_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rows_q      <= rows_d;
      row_cnt_q   <= row_cnt_d;
      row_data_q  <= row_data_d;
      row_valid_q <= row_valid_d;
      row_index_q <= row_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign row_data  = row_data_q;
  assign row_valid = row_valid_q;
  assign row_index = row_index_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
